// File: rtl/shift_add_mul.sv
// Sequential unsigned multiplier: one shift-add step per clock, multiplier bits LSB-first.
// Produces a registered 2*n-bit product after n RUN cycles and a one-cycle done pulse.
module shift_add_mul #(
  parameter int unsigned n = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [n-1:0]     a,
  input  logic [n-1:0]     b,
  output logic [2*n-1:0]   p,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(n + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [n-1:0]     mcand_q, mcand_d;
  logic [2*n:0]     acc_q, acc_d;
  logic [2*n:0]     acc_step;
  logic [n:0]       upper_sum;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*n-1:0]   p_q, p_d;

  always_comb begin
    // Upper half plus multiplicand keeps its carry in bit 2n, then the whole
    // accumulator shifts right with zero fill.
    upper_sum = {1'b0, acc_q[2*n-1:n]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step  = {1'b0, upper_sum, acc_q[n-1:1]};
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d = a;
          acc_d   = {{(n + 1){1'b0}}, b};
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(n - 1)) begin
          p_d     = acc_step[2*n-1:0];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign p    = p_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_shift_add_mul.sv
// Scoreboard bench for shift_add_mul: directed n=8 vectors and a default-width (n=37) sweep.
// Stimulus pushes expected product and issue cycle; monitors pop and compare on done.
module tb_shift_add_mul;

  localparam int unsigned N8  = 8;
  localparam int unsigned N37 = 37;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic              rst8, start8, busy8, done8;
  logic [N8-1:0]     a8, b8;
  logic [2*N8-1:0]   p8;
  logic              rst37, start37, busy37, done37;
  logic [N37-1:0]    a37, b37;
  logic [2*N37-1:0]  p37;

  shift_add_mul #(.n(N8)) u_dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .p(p8), .busy(busy8), .done(done8)
  );

  shift_add_mul u_dut37 (
    .clk(clk), .rst(rst37), .start(start37), .a(a37), .b(b37),
    .p(p37), .busy(busy37), .done(done37)
  );

  typedef struct { logic [15:0] p; int unsigned t; } exp8_t;
  typedef struct { logic [73:0] p; int unsigned t; } exp37_t;
  exp8_t  q8[$];
  exp37_t q37[$];
  logic [15:0] hold8 = '0;
  int unsigned run8 = 0;
  int unsigned run37 = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor for the n=8 instance: result, latency, busy length, p stability.
  always @(negedge clk) begin : mon8
    exp8_t e;
    if (!rst8) begin
      if (done8) begin
        check("busy_done_excl8", 128'(busy8), 128'(0));
        check("busy_len8", 128'(run8), 128'(N8));
        if (q8.size() == 0) begin
          check("unexpected_done8", 128'(1), 128'(0));
        end else begin
          e = q8.pop_front();
          check("p8", 128'(p8), 128'(e.p));
          check("latency8", 128'(cyc - e.t), 128'(N8 + 1));
          hold8 = e.p;
        end
        run8 = 0;
      end else begin
        check("p8_hold", 128'(p8), 128'(hold8));
        run8 = busy8 ? run8 + 1 : 0;
      end
    end else begin
      run8 = 0;
    end
  end

  always @(negedge clk) begin : mon37
    exp37_t e;
    if (!rst37) begin
      if (done37) begin
        check("busy_done_excl37", 128'(busy37), 128'(0));
        check("busy_len37", 128'(run37), 128'(N37));
        if (q37.size() == 0) begin
          check("unexpected_done37", 128'(1), 128'(0));
        end else begin
          e = q37.pop_front();
          check("p37", 128'(p37), 128'(e.p));
          check("latency37", 128'(cyc - e.t), 128'(N37 + 1));
        end
        run37 = 0;
      end else begin
        run37 = busy37 ? run37 + 1 : 0;
      end
    end else begin
      run37 = 0;
    end
  end

  // Caller is positioned just after a negedge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] expp);
    a8 = a;
    b8 = b;
    start8 = 1'b1;
    q8.push_back('{expp, cyc});
  endtask

  task automatic stim8();
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("rst_p8", 128'(p8), 128'(0));
    check("rst_busy8", 128'(busy8), 128'(0));
    check("rst_done8", 128'(done8), 128'(0));
    // start presented on the very first edge after reset release
    rst8 = 1'b0;
    issue8(8'd13, 8'd11, 16'd143);
    @(negedge clk) start8 = 1'b0;
    repeat (N8 + 1) @(negedge clk);
    check("idle_busy8", 128'(busy8), 128'(0));
    check("idle_done8", 128'(done8), 128'(0));

    issue8(8'd255, 8'd255, 16'd65025);
    @(negedge clk) start8 = 1'b0;
    repeat (N8 + 1) @(negedge clk);
    issue8(8'd0, 8'd200, 16'd0);
    @(negedge clk) start8 = 1'b0;
    repeat (N8 + 1) @(negedge clk);

    // start during RUN must be ignored
    issue8(8'd13, 8'd11, 16'd143);
    @(negedge clk) start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'd1; b8 = 8'd1; start8 = 1'b1;
    @(negedge clk) start8 = 1'b0;
    repeat (N8 + 2) @(negedge clk);

    // start held through DONE: back-to-back operations
    issue8(8'd3, 8'd5, 16'd15);
    @(negedge clk) begin a8 = 8'd7; b8 = 8'd9; end
    repeat (N8) @(negedge clk);
    check("b2b_done8", 128'(done8), 128'(1));
    q8.push_back('{16'd63, cyc});
    @(negedge clk) start8 = 1'b0;
    repeat (N8 + 2) @(negedge clk);

    // reset in the fourth RUN cycle aborts the operation
    issue8(8'd200, 8'd100, 16'd20000);
    @(negedge clk) start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    hold8 = '0;
    q8.delete();
    @(negedge clk);
    check("abort_p8", 128'(p8), 128'(0));
    check("abort_busy8", 128'(busy8), 128'(0));
    check("abort_done8", 128'(done8), 128'(0));
    rst8 = 1'b0;
    repeat (N8 + 3) @(negedge clk);
    issue8(8'd12, 8'd12, 16'd144);
    @(negedge clk) start8 = 1'b0;
    repeat (N8 + 2) @(negedge clk);
  endtask

  task automatic stim37();
    logic [63:0] r;
    logic [73:0] ea, eb;
    int unsigned j;
    rst37 = 1'b1; start37 = 1'b0; a37 = '0; b37 = '0;
    repeat (2) @(negedge clk);
    check("rst_p37", 128'(p37), 128'(0));
    rst37 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 0) begin
        a37 = '1; b37 = '1;
      end else if (i == 1) begin
        a37 = '0; b37 = '1;
      end else if (i == 2) begin
        a37 = '1; b37 = '0;
      end else begin
        r = {$urandom(), $urandom()};
        a37 = r[36:0];
        r = {$urandom(), $urandom()};
        b37 = r[36:0];
      end
      ea = 74'(a37);
      eb = 74'(b37);
      start37 = 1'b1;
      q37.push_back('{ea * eb, cyc});
      @(negedge clk) start37 = 1'b0;
      j = 0;
      while (!done37 && j < 60) begin
        @(negedge clk);
        j++;
      end
      if (!done37) begin
        check("timeout37", 128'(0), 128'(1));
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    fork
      stim8();
      stim37();
    join
    for (int k = 0; k < 100 && (q8.size() != 0 || q37.size() != 0); k++) @(negedge clk);
    check("drain8", 128'(q8.size()), 128'(0));
    check("drain37", 128'(q37.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
